// File: rtl/display_scan_driver.sv
// display_scan_driver
// Converts a 14-bit binary result to four BCD digits with a sequential
// double-dabble, then scans them onto a 4-digit common-anode 7-segment
// display, one digit per next_data pulse. New results are committed only
// at frame boundaries, so a single frame never mixes old and new digits.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   defined   -> digits above the most significant non-zero digit are blanked
//                (digit 0 and overflow dashes are always shown)
//   undefined -> all four digits are always shown
module display_scan_driver (
  input  logic        clk,
  input  logic        reset,
  input  logic        next_data,
  input  logic        load,
  input  logic [13:0] value,
  output logic        busy,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int NUM_BITS = 14;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  // Internal digit codes: 0..9 are decimal digits, DASH marks overflow,
  // BLANK turns every segment off.
  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  localparam logic [3:0] LAST_SHIFT = 4'(NUM_BITS - 1);

  logic [1:0]          state;
  logic [NUM_BITS-1:0] bin_sr;
  logic [15:0]         bcd;
  logic [15:0]         bcd_adj;
  logic [3:0]          count;
  logic                ovf;

  logic [15:0]         pending;
  logic                pending_new;
  logic [15:0]         shadow;
  logic [1:0]          idx;

  logic                commit;
  logic [15:0]         commit_word;
  logic                frame_edge;
  logic [1:0]          idx_next;
  logic [15:0]         shadow_next;
  logic [3:0]          digit_code;
  logic [3:0]          shown_code;
  logic [3:0]          an_next;
  logic [6:0]          seg_next;

  // Active-low segment pattern {g,f,e,d,c,b,a} for an internal digit code.
  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:      decode = 7'b1000000;
      4'd1:      decode = 7'b1111001;
      4'd2:      decode = 7'b0100100;
      4'd3:      decode = 7'b0110000;
      4'd4:      decode = 7'b0011001;
      4'd5:      decode = 7'b0010010;
      4'd6:      decode = 7'b0000010;
      4'd7:      decode = 7'b1111000;
      4'd8:      decode = 7'b0000000;
      4'd9:      decode = 7'b0010000;
      CODE_DASH: decode = 7'b0111111;
      default:   decode = 7'b1111111;
    endcase
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Converter FSM: latch on load, shift NUM_BITS times, then commit once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      bin_sr <= '0;
      bcd    <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bin_sr <= value;
            bcd    <= '0;
            count  <= '0;
            ovf    <= (value > 14'd9999);
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
          count         <= count + 4'd1;
          if (count == LAST_SHIFT) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Commit strobe and the word it writes; overflow replaces all digits with dashes.
  always_comb begin
    commit      = (state == COMMIT);
    commit_word = ovf ? {4{CODE_DASH}} : bcd;
  end

  // Next scan position and the digit it will show, taken from the shadow as
  // it will be after a possible frame-boundary update on this edge.
  always_comb begin
    frame_edge  = next_data && (idx == 2'd3) && pending_new;
    idx_next    = idx + 2'd1;
    shadow_next = frame_edge ? pending : shadow;
    digit_code  = shadow_next[4*idx_next +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    shown_code = digit_code;
    case (idx_next)
      2'd3: if (shadow_next[15:12] == 4'd0) shown_code = CODE_BLANK;
      2'd2: if (shadow_next[15:8]  == 8'd0) shown_code = CODE_BLANK;
      2'd1: if (shadow_next[15:4]  == 12'd0) shown_code = CODE_BLANK;
      default: shown_code = digit_code;
    endcase
`else
    shown_code = digit_code;
`endif
    an_next  = ~(4'b0001 << idx_next);
    seg_next = decode(shown_code);
  end

  // Scan registers, pending/shadow double buffer and frame-boundary hand-over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending     <= {4{CODE_BLANK}};
      pending_new <= 1'b0;
      shadow      <= {4{CODE_BLANK}};
      idx         <= 2'd0;
      an          <= 4'hF;
      seg         <= 7'h7F;
    end else begin
      if (next_data) begin
        idx <= idx_next;
        an  <= an_next;
        seg <= seg_next;
        if (frame_edge) begin
          shadow <= pending;
        end
      end
      if (commit) begin
        pending     <= commit_word;
        pending_new <= 1'b1;
      end else if (frame_edge) begin
        pending_new <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// tb_display_scan_driver
// Directed, table-driven bench for display_scan_driver. Expected segment
// patterns are hand-written constants. Honours LEADING_ZERO_BLANK_EN when
// choosing expected digits for values with leading zeros.
module tb_display_scan_driver;

  localparam logic [6:0] S0    = 7'b1000000;
  localparam logic [6:0] S1    = 7'b1111001;
  localparam logic [6:0] S2    = 7'b0100100;
  localparam logic [6:0] S3    = 7'b0110000;
  localparam logic [6:0] S4    = 7'b0011001;
  localparam logic [6:0] S5    = 7'b0010010;
  localparam logic [6:0] S6    = 7'b0000010;
  localparam logic [6:0] S7    = 7'b1111000;
  localparam logic [6:0] S8    = 7'b0000000;
  localparam logic [6:0] S9    = 7'b0010000;
  localparam logic [6:0] SDASH = 7'b0111111;
  localparam logic [6:0] SBLNK = 7'b1111111;

  typedef struct {
    string            name;
    logic [13:0]      value;
    logic [3:0][6:0]  exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        next_data;
  logic        load;
  logic [13:0] value;
  logic        busy;
  logic [3:0]  an;
  logic [6:0]  seg;

  int tests_run;
  int tests_failed;

  display_scan_driver dut (
    .clk       (clk),
    .reset     (reset),
    .next_data (next_data),
    .load      (load),
    .value     (value),
    .busy      (busy),
    .an        (an),
    .seg       (seg)
  );

  // Free-running 100 MHz-style clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [13:0] v);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    if (busy) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: busy still high after %0d cycles, expected low", name, n);
    end
  endtask

  // Holds next_data high for 8 cycles from idx 0; the second frame
  // (cycles 4..7) and the wrap back to digit 0 must show exp.
  task automatic verifyFrame(input string name, input logic [3:0][6:0] exp);
    logic [1:0] pos;
    next_data = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      pos = 2'(k % 4);
      checkOutput({name, " an"}, {12'd0, an}, {12'd0, ~(4'b0001 << pos)});
      if (k >= 4) begin
        checkOutput({name, " seg"}, {9'd0, seg}, {9'd0, exp[pos]});
      end
    end
    next_data = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    logic [3:0][6:0] old_frame;
    logic [3:0][6:0] new_frame;
    int busy_cycles;

    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    next_data    = 1'b0;
    load         = 1'b0;
    value        = '0;

    vecs[0] = '{"v1234",  14'd1234,  {S1, S2, S3, S4}};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[1] = '{"v42",    14'd42,    {SBLNK, SBLNK, S4, S2}};
    vecs[2] = '{"v0",     14'd0,     {SBLNK, SBLNK, SBLNK, S0}};
`else
    vecs[1] = '{"v42",    14'd42,    {S0, S0, S4, S2}};
    vecs[2] = '{"v0",     14'd0,     {S0, S0, S0, S0}};
`endif
    vecs[3] = '{"v9999",  14'd9999,  {S9, S9, S9, S9}};
    vecs[4] = '{"v12000", 14'd12000, {SDASH, SDASH, SDASH, SDASH}};
    vecs[5] = '{"v16383", 14'd16383, {SDASH, SDASH, SDASH, SDASH}};

    // Reset state
    tick();
    tick();
    checkOutput("rst busy", {15'd0, busy}, 16'd0);
    checkOutput("rst an",   {12'd0, an},   16'h000F);
    checkOutput("rst seg",  {9'd0, seg},   16'h007F);
    reset = 1'b0;
    tick();

    // First frame after reset is blank on every digit
    next_data = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput("blank an",  {12'd0, an},  {12'd0, ~(4'b0001 << 2'(k % 4))});
      checkOutput("blank seg", {9'd0, seg},  16'h007F);
    end
    next_data = 1'b0;

    // busy lasts exactly 15 cycles from the load edge
    applyStimulus(14'd1234);
    busy_cycles = 0;
    for (int n = 0; n < 40 && busy; n++) begin
      busy_cycles++;
      tick();
    end
    checkOutput("busy len", 16'(busy_cycles), 16'd15);
    verifyFrame("first1234", {S1, S2, S3, S4});

    // Table of values
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].value);
      waitIdle(vecs[i].name);
      verifyFrame(vecs[i].name, vecs[i].exp);
    end

    // Load during busy is dropped
    applyStimulus(14'd5555);
    tick();
    applyStimulus(14'd7);
    waitIdle("ign7");
    verifyFrame("ign7", {S5, S5, S5, S5});

    // Load on the first cycle after busy drops is accepted
    applyStimulus(14'd1111);
    waitIdle("n16a");
    applyStimulus(14'd2222);
    checkOutput("n16 busy", {15'd0, busy}, 16'd1);
    waitIdle("n16b");
    verifyFrame("n16", {S2, S2, S2, S2});

    // Commit on the same edge as the idx==3 frame boundary
    old_frame = {S2, S2, S2, S2};
    new_frame = {S6, S7, S8, S9};
    applyStimulus(14'd6789);
    for (int e = 1; e <= 15; e++) begin
      next_data = (e <= 3 || e == 15);
      tick();
      if (e <= 3) begin
        checkOutput("coin early", {9'd0, seg}, {9'd0, old_frame[e]});
      end
    end
    next_data = 1'b0;
    checkOutput("coin busy", {15'd0, busy}, 16'd0);
    checkOutput("coin d0",   {9'd0, seg},   {9'd0, old_frame[0]});
    next_data = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k <= 3) begin
        checkOutput("coin old", {9'd0, seg}, {9'd0, old_frame[k]});
      end else begin
        checkOutput("coin new", {9'd0, seg}, {9'd0, new_frame[k % 4]});
      end
    end
    next_data = 1'b0;

    // Reset in the middle of SHIFT
    applyStimulus(14'd3333);
    for (int n = 0; n < 5; n++) tick();
    reset = 1'b1;
    #1;
    checkOutput("mid rst busy", {15'd0, busy}, 16'd0);
    checkOutput("mid rst an",   {12'd0, an},   16'h000F);
    tick();
    reset = 1'b0;
    tick();
    next_data = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkOutput("post rst seg", {9'd0, seg}, 16'h007F);
    end
    next_data = 1'b0;
    checkOutput("post rst busy", {15'd0, busy}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
